// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: IFU, LSU and memory buses of mem_arbiter; slave = arbiter side, master = requesters/memory side
interface mem_arbiter_if;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_ack, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_ack, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: LSU-priority IFU/LSU arbiter onto one memory port with IFU starvation guard; ports clk, rst (async active-low), bus (mem_arbiter_if.slave)
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {IFU, LSU} owner_t;
  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          we_q, we_d, if_rvalid_q, if_rvalid_d, ls_rvalid_q, ls_rvalid_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
  logic          starving, if_win, gnt_if, gnt_ls, done;
  always_comb begin
    starving    = starve_q == CW'(STARVE_LIMIT);
    if_win      = bus.if_req & (~bus.ls_req | starving);
    gnt_if      = rst & (state_q == IDLE) & if_win;
    gnt_ls      = rst & (state_q == IDLE) & bus.ls_req & ~if_win;
    done        = (state_q == BUSY) & bus.mem_ack;
    state_d     = (gnt_if | gnt_ls) ? BUSY : done ? IDLE : state_q;
    owner_d     = gnt_ls ? LSU : gnt_if ? IFU : owner_q;
    we_d        = gnt_ls ? bus.ls_we : gnt_if ? 1'b0 : we_q;
    addr_d      = gnt_ls ? bus.ls_addr : gnt_if ? bus.if_addr : addr_q;
    wdata_d     = gnt_ls ? bus.ls_wdata : gnt_if ? 32'd0 : wdata_q;
    starve_d    = gnt_if ? '0 : !gnt_ls ? starve_q : !bus.if_req ? '0 : starving ? starve_q : starve_q + CW'(1);
    if_rvalid_d = done & (owner_q == IFU);
    ls_rvalid_d = done & (owner_q == LSU);
    if_rdata_d  = if_rvalid_d ? bus.mem_rdata : if_rdata_q;
    ls_rdata_d  = (ls_rvalid_d & ~we_q) ? bus.mem_rdata : ls_rdata_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= IFU;
      starve_q    <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  assign bus.if_gnt    = gnt_if;
  assign bus.ls_gnt    = gnt_ls;
  assign bus.mem_req   = state_q == BUSY;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.ls_rvalid = ls_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rdata  = ls_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: transaction-level model plus directed scenarios for mem_arbiter
module tb_mem_arbiter;
  localparam int LIMIT = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  mem_arbiter_if bus();
  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.clk(clk), .rst(rst), .bus(bus));
  int vectors = 0;
  int miscompares = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  logic        m_busy, m_ls, m_we, m_ifv, m_lsv;
  logic [31:0] m_addr, m_wdata, m_ifd, m_lsd;
  int          m_starve;
  logic        eg_if, eg_ls;
  always_comb begin
    eg_ls = rst && !m_busy && bus.ls_req && !(bus.if_req && m_starve >= LIMIT);
    eg_if = rst && !m_busy && bus.if_req && !eg_ls;
  end
  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_busy   <= 1'b0;
      m_ls     <= 1'b0;
      m_we     <= 1'b0;
      m_ifv    <= 1'b0;
      m_lsv    <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_ifd    <= '0;
      m_lsd    <= '0;
      m_starve <= 0;
    end else begin
      m_ifv <= 1'b0;
      m_lsv <= 1'b0;
      if (m_busy && bus.mem_ack) begin
        m_busy <= 1'b0;
        if (m_ls) begin
          m_lsv <= 1'b1;
          if (!m_we) m_lsd <= bus.mem_rdata;
        end else begin
          m_ifv <= 1'b1;
          m_ifd <= bus.mem_rdata;
        end
      end else if (eg_ls || eg_if) begin
        m_busy   <= 1'b1;
        m_ls     <= eg_ls;
        m_we     <= eg_ls && bus.ls_we;
        m_addr   <= eg_ls ? bus.ls_addr : bus.if_addr;
        m_wdata  <= eg_ls ? bus.ls_wdata : 32'd0;
        m_starve <= (eg_ls && bus.if_req) ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
      end
    end
  int glog[$];
  int n_ifv = 0;
  int n_lsv = 0;
  logic g_if = 1'b0;
  logic g_ls = 1'b0;
  initial forever begin
    @(negedge clk);
    g_if = bus.if_gnt;
    g_ls = bus.ls_gnt;
    if (bus.ls_gnt) glog.push_back(1);
    if (bus.if_gnt) glog.push_back(2);
    if (bus.if_rvalid) n_ifv++;
    if (bus.ls_rvalid) n_lsv++;
    if (!rst) begin
      chk("rst_if_gnt", bus.if_gnt, 0);
      chk("rst_ls_gnt", bus.ls_gnt, 0);
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_if_rvalid", bus.if_rvalid, 0);
      chk("rst_ls_rvalid", bus.ls_rvalid, 0);
      chk("rst_if_rdata", bus.if_rdata, 0);
      chk("rst_ls_rdata", bus.ls_rdata, 0);
    end else begin
      chk("if_gnt", bus.if_gnt, eg_if);
      chk("ls_gnt", bus.ls_gnt, eg_ls);
      chk("mem_req", bus.mem_req, m_busy);
      if (m_busy) begin
        chk("mem_we", bus.mem_we, m_we);
        chk("mem_addr", bus.mem_addr, m_addr);
        chk("mem_wdata", bus.mem_wdata, m_wdata);
      end
      chk("if_rvalid", bus.if_rvalid, m_ifv);
      chk("ls_rvalid", bus.ls_rvalid, m_lsv);
      chk("if_rdata", bus.if_rdata, m_ifd);
      chk("ls_rdata", bus.ls_rdata, m_lsd);
    end
  end
  logic        auto_drop = 1'b1;
  logic        stray = 1'b0;
  int          ack_delay = 1;
  int          busy_n = 0;
  logic [31:0] rd_val = '0;
  logic [31:0] rd_step = '0;
  task automatic cyc();
    @(posedge clk);
    #1;
    if (auto_drop && g_if) bus.if_req = 1'b0;
    if (auto_drop && g_ls) bus.ls_req = 1'b0;
    if (bus.mem_req) begin
      busy_n++;
      bus.mem_ack = busy_n >= ack_delay;
    end else begin
      busy_n = 0;
      bus.mem_ack = stray;
    end
    rd_val = rd_val + rd_step;
    bus.mem_rdata = rd_val;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask
  int pat[10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
  int ifv0, lsv0;
  initial begin
    bus.if_req = 1'b1;
    bus.if_addr = 32'h0;
    bus.ls_req = 1'b1;
    bus.ls_we = 1'b0;
    bus.ls_addr = 32'h100;
    bus.ls_wdata = 32'h0;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h0;
    run(3);
    bus.if_req = 1'b0;
    bus.mem_ack = 1'b0;
    rd_val = 32'hDEADBEEF;
    ack_delay = 2;
    rst = 1'b1;
    @(negedge clk);
    chk("first_gnt_after_rst", bus.ls_gnt, 1);
    cyc();
    chk("load_addr_busy1", bus.mem_addr, 32'h100);
    cyc();
    chk("load_addr_busy2", bus.mem_addr, 32'h100);
    cyc();
    chk("load_rvalid", bus.ls_rvalid, 1);
    chk("load_rdata", bus.ls_rdata, 32'hDEADBEEF);
    cyc();
    chk("load_rvalid_pulse", bus.ls_rvalid, 0);
    lsv0 = n_lsv;
    bus.ls_req = 1'b1;
    bus.ls_we = 1'b1;
    bus.ls_addr = 32'h40;
    bus.ls_wdata = 32'h12345678;
    rd_val = 32'h55AA55AA;
    ack_delay = 3;
    cyc();
    chk("store_we", bus.mem_we, 1);
    chk("store_wdata", bus.mem_wdata, 32'h12345678);
    run(5);
    chk("store_rvalid_count", n_lsv - lsv0, 1);
    chk("store_keeps_rdata", bus.ls_rdata, 32'hDEADBEEF);
    bus.ls_we = 1'b0;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h200;
    rd_val = 32'hCAFEF00D;
    ack_delay = 1;
    run(4);
    chk("fetch_rdata", bus.if_rdata, 32'hCAFEF00D);
    chk("fetch_leaves_ls_rdata", bus.ls_rdata, 32'hDEADBEEF);
    glog.delete();
    bus.if_req = 1'b1;
    bus.if_addr = 32'h204;
    bus.ls_req = 1'b1;
    bus.ls_addr = 32'h300;
    rd_val = 32'h11111111;
    run(6);
    chk("sim_grants", glog.size(), 2);
    chk("sim_first_lsu", glog[0], 1);
    chk("sim_then_ifu", glog[1], 2);
    glog.delete();
    auto_drop = 1'b0;
    rd_step = 32'h1;
    bus.if_req = 1'b1;
    bus.ls_req = 1'b1;
    run(20);
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    auto_drop = 1'b1;
    rd_step = 32'h0;
    run(3);
    chk("starve_grant_count", glog.size() >= 10, 1);
    for (int i = 0; i < 10; i++) chk($sformatf("starve_seq%0d", i), glog[i], pat[i]);
    ifv0 = n_ifv;
    lsv0 = n_lsv;
    stray = 1'b1;
    run(3);
    stray = 1'b0;
    run(2);
    chk("stray_no_ifv", n_ifv - ifv0, 0);
    chk("stray_no_lsv", n_lsv - lsv0, 0);
    bus.ls_req = 1'b1;
    bus.ls_addr = 32'h500;
    ack_delay = 5;
    run(3);
    chk("midop_busy", bus.mem_req, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("midop_mem_req_drop", bus.mem_req, 0);
    run(2);
    rst = 1'b1;
    stray = 1'b1;
    run(3);
    stray = 1'b0;
    run(2);
    chk("midop_no_lsv", n_lsv - lsv0, 0);
    chk("midop_ls_rdata_cleared", bus.ls_rdata, 0);
    glog.delete();
    bus.if_req = 1'b1;
    bus.ls_req = 1'b1;
    ack_delay = 1;
    run(6);
    chk("post_rst_first_lsu", glog.size() >= 1 ? glog[0] : 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive LSU grants allowed while IFU waits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port if_req  input  1  instruction-fetch request; held until if_gnt.
REQ-005 SHALL have port if_addr  input  32  fetch address.
REQ-006 SHALL have port if_gnt  output  1  fetch request accepted.
REQ-007 SHALL have port if_rvalid  output  1  fetch data valid, 1-cycle pulse.
REQ-008 SHALL have port if_rdata  output  32  fetch data.
REQ-009 SHALL have port ls_req  input  1  load/store request; held until ls_gnt.
REQ-010 SHALL have port ls_we  input  1  1 = store, 0 = load.
REQ-011 SHALL have port ls_addr  input  32  load/store address.
REQ-012 SHALL have port ls_wdata  input  32  store data.
REQ-013 SHALL have port ls_gnt  output  1  load/store request accepted.
REQ-014 SHALL have port ls_rvalid  output  1  load data valid or store complete, 1-cycle pulse.
REQ-015 SHALL have port ls_rdata  output  32  load data.
REQ-016 SHALL have port mem_req  output  1  memory request, held until mem_ack.
REQ-017 SHALL have port mem_we  output  1  memory write enable.
REQ-018 SHALL have port mem_addr  output  32  memory address.
REQ-019 SHALL have port mem_wdata  output  32  memory write data.
REQ-020 SHALL have port mem_ack  input  1  memory completes the request this cycle.
REQ-021 SHALL have port mem_rdata  input  32  read data, valid when mem_ack=1.

Function
REQ-022 SHALL implement FSM with states IDLE and BUSY, plus registers owner (IFU/LSU) and starve_cnt (width clog2(STARVE_LIMIT+1)).
REQ-023 In IDLE, SHALL accept at most one request per cycle: if_gnt/ls_gnt combinational, high only in the acceptance cycle, mutually exclusive.
REQ-024 Arbitration: LSU wins over IFU, except IFU wins when both request and starve_cnt == STARVE_LIMIT.
REQ-025 On acceptance SHALL latch addr, we (IFU forces 0), wdata (IFU forces 0), and owner; next cycle state = BUSY.
REQ-026 In BUSY, mem_req=1 with latched mem_we/mem_addr/mem_wdata, stable until mem_ack; no grants issued.
REQ-027 On mem_ack in BUSY: next cycle state = IDLE, owner's rvalid pulses 1 cycle; owner's rdata register loads mem_rdata (loads and fetches only; stores leave ls_rdata unchanged).
REQ-028 Non-owner rdata/rvalid SHALL be unaffected; rdata holds last value between transactions.
REQ-029 Back-to-back: the rvalid cycle is an IDLE cycle and may grant a new request; minimum 2 cycles per transaction (mem_ack immediate).
REQ-030 starve_cnt: +1 on LSU grant while if_req=1 (saturating at STARVE_LIMIT); cleared on IFU grant or on LSU grant with if_req=0.
REQ-031 mem_ack while IDLE SHALL be ignored (no state change, no rvalid).
REQ-032 Requests arriving while BUSY SHALL wait; requester keeps req high, no requirement to drop after gnt but a held req after gnt counts as a new request.
REQ-033 mem_req SHALL be 0 in IDLE; mem_we/mem_addr/mem_wdata don't-care when mem_req=0.

Reset
REQ-034 rst=0 SHALL asynchronously force IDLE, owner=IFU, starve_cnt=0, mem_req/mem_we=0, mem_addr/mem_wdata=0, both rvalid=0, both rdata=0; gnt outputs 0 while rst=0.
REQ-035 Reset mid-BUSY SHALL abandon the transaction: no rvalid afterwards, later mem_ack ignored.
REQ-036 First grant possible on the first rising edge after rst returns to 1.

Verification
REQ-037 Single load: ls_req, ls_we=0, ls_addr=0x100; mem_ack 2 cycles into BUSY with mem_rdata=0xDEADBEEF -> ls_gnt 1 cycle, mem_addr=0x100 held, ls_rvalid pulse next cycle, ls_rdata=0xDEADBEEF.
REQ-038 Simultaneous: if_req and ls_req same cycle, starve_cnt=0 -> ls_gnt first; IFU granted in rvalid cycle of LSU transaction.
REQ-039 Starvation: if_req and ls_req held continuously, mem_ack immediate -> exactly 4 LSU grants then 1 IFU grant, then LSU again; pattern repeats.
REQ-040 Store: ls_we=1, ls_wdata=0x12345678, ls_addr=0x40 -> mem_we=1, mem_wdata=0x12345678 until mem_ack; ls_rvalid pulse; ls_rdata unchanged.
REQ-041 Reset mid-op: rst low while BUSY, then mem_ack after release -> mem_req=0 immediately, no rvalid, state IDLE, starve_cnt=0.
REQ-042 Stray ack: mem_ack=1 in IDLE with no requests -> no rvalid, mem_req stays 0.
